// File: rtl/vector_reg_file.sv
// vector_reg_file: 8 x 8 x 32-bit vector register file fed by the vector
// write-back stage. A write FSM (IDLE/WRITE/DONE) stores an element stream
// into one register. Two registered read ports share one element index.
// Optional feature macro: VRF_WRITE_BYPASS_EN (write-first read ports);
// when undefined the read ports are read-first and no bypass logic exists.
//
// Handshake: wr_start is a one-cycle request, honoured only in IDLE. While
// busy, an element is consumed at every rising edge where wr_valid is high
// (the write side is always ready in WRITE). wr_valid is ignored outside
// WRITE. wr_done pulses for one cycle when the stream is complete; the next
// wr_start is honoured in the cycle after that pulse.
`timescale 1ns/1ps
module vector_reg_file #(
  parameter int NUM_VREGS = 8,
  parameter int MAX_VL    = 8,
  parameter int DATA_W    = 32
) (
  input  logic                         clk,
  input  logic                         pc_rst,
  input  logic                         wr_start,
  input  logic [$clog2(NUM_VREGS)-1:0] wr_vreg,
  input  logic [31:0]                  VLR,
  input  logic                         wr_valid,
  input  logic [DATA_W-1:0]            Write_Data,
  output logic                         wr_busy,
  output logic                         wr_done,
  input  logic [$clog2(NUM_VREGS)-1:0] rd_vreg_a,
  input  logic [$clog2(NUM_VREGS)-1:0] rd_vreg_b,
  input  logic [$clog2(MAX_VL)-1:0]    rd_elem,
  output logic [DATA_W-1:0]            rd_data_a,
  output logic [DATA_W-1:0]            rd_data_b,
  output logic [1:0]                   dbg_state
);

  localparam int VW = $clog2(NUM_VREGS);
  localparam int EW = $clog2(MAX_VL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [VW-1:0]     vreg_q;
  logic [EW-1:0]     idx_q;
  // Index of the final element to write, i.e. min(VLR, MAX_VL) - 1.
  logic [EW-1:0]     last_q;
  logic [DATA_W-1:0] mem [NUM_VREGS][MAX_VL];
  logic              we;

  // An element is stored only while the FSM is in WRITE.
  assign we        = (state == S_WRITE) && wr_valid;
  assign dbg_state = state;

  // Write FSM: latches target and length, walks the element index, and
  // produces the registered busy/done flags.
  always_ff @(posedge clk or posedge pc_rst) begin
    if (pc_rst) begin
      state   <= S_IDLE;
      vreg_q  <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      wr_busy <= 1'b0;
      wr_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          wr_done <= 1'b0;
          if (wr_start) begin
            vreg_q  <= wr_vreg;
            idx_q   <= '0;
            wr_busy <= 1'b1;
            if (VLR == 32'd0) begin
              // Zero-length write completes without touching storage.
              state   <= S_DONE;
              wr_done <= 1'b1;
            end else begin
              state  <= S_WRITE;
              last_q <= (VLR >= 32'(MAX_VL)) ? EW'(MAX_VL - 1) : EW'(VLR - 32'd1);
            end
          end
        end
        S_WRITE: begin
          if (wr_valid) begin
            if (idx_q == last_q) begin
              state   <= S_DONE;
              wr_done <= 1'b1;
            end else begin
              idx_q <= idx_q + EW'(1);
            end
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          wr_done <= 1'b0;
          wr_busy <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          wr_done <= 1'b0;
          wr_busy <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: cleared by reset, one element written per accepted beat.
  always_ff @(posedge clk or posedge pc_rst) begin
    if (pc_rst) begin
      for (int v = 0; v < NUM_VREGS; v++) begin
        for (int e = 0; e < MAX_VL; e++) begin
          mem[v][e] <= '0;
        end
      end
    end else if (we) begin
      mem[vreg_q][idx_q] <= Write_Data;
    end
  end

`ifdef VRF_WRITE_BYPASS_EN
  logic hit_a;
  logic hit_b;

  // Each port independently detects a same-edge write to its location.
  assign hit_a = we && (rd_vreg_a == vreg_q) && (rd_elem == idx_q);
  assign hit_b = we && (rd_vreg_b == vreg_q) && (rd_elem == idx_q);

  // Registered read ports, write-first: a colliding write is forwarded.
  always_ff @(posedge clk or posedge pc_rst) begin
    if (pc_rst) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_data_a <= hit_a ? Write_Data : mem[rd_vreg_a][rd_elem];
      rd_data_b <= hit_b ? Write_Data : mem[rd_vreg_b][rd_elem];
    end
  end
`else
  // Registered read ports, read-first: a colliding write is not yet visible.
  always_ff @(posedge clk or posedge pc_rst) begin
    if (pc_rst) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_data_a <= mem[rd_vreg_a][rd_elem];
      rd_data_b <= mem[rd_vreg_b][rd_elem];
    end
  end
`endif

endmodule

// File: tb/tb_vector_reg_file.sv
// tb_vector_reg_file: randomized bench for vector_reg_file with a plain
// array model of the register contents and an expected-value queue.
`timescale 1ns/1ps
module tb_vector_reg_file;

  localparam int NV = 8;
  localparam int VL = 8;
  localparam int W  = 32;

  typedef logic [W-1:0] vec_t [VL];

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic pc_rst = 1'b0;
  always #5 clk = ~clk;

  logic         wr_start = 1'b0;
  logic [2:0]   wr_vreg = '0;
  logic [31:0]  VLR = '0;
  logic         wr_valid = 1'b0;
  logic [W-1:0] Write_Data = '0;
  logic         wr_busy;
  logic         wr_done;
  logic [2:0]   rd_vreg_a = '0;
  logic [2:0]   rd_vreg_b = '0;
  logic [2:0]   rd_elem = '0;
  logic [W-1:0] rd_data_a;
  logic [W-1:0] rd_data_b;
  logic [1:0]   dbg_state;

  // Reference model: register contents as a plain 2-D array.
  logic [W-1:0] exp_mem [NV][VL];
  logic [W-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  vector_reg_file dut (
    .clk        (clk),
    .pc_rst     (pc_rst),
    .wr_start   (wr_start),
    .wr_vreg    (wr_vreg),
    .VLR        (VLR),
    .wr_valid   (wr_valid),
    .Write_Data (Write_Data),
    .wr_busy    (wr_busy),
    .wr_done    (wr_done),
    .rd_vreg_a  (rd_vreg_a),
    .rd_vreg_b  (rd_vreg_b),
    .rd_elem    (rd_elem),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .dbg_state  (dbg_state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_pair(input int va, input int vb, input int e,
                           output logic [W-1:0] a, output logic [W-1:0] b);
    rd_vreg_a = 3'(va);
    rd_vreg_b = 3'(vb);
    rd_elem   = 3'(e);
    step();
    a = rd_data_a;
    b = rd_data_b;
  endtask

  task automatic clear_model();
    for (int v = 0; v < NV; v++)
      for (int e = 0; e < VL; e++)
        exp_mem[v][e] = '0;
  endtask

  task automatic rand_vec(output vec_t d);
    for (int e = 0; e < VL; e++) d[e] = $urandom;
  endtask

  // Drives one complete vector write. stall_pct < 0 selects an alternating
  // valid pattern 1,0,1,0,... ; mid_start pulses a competing wr_start in
  // stall cycles. Returns edges from wr_start to wr_done and the read-port
  // values captured right after the edge that wrote the final element.
  task automatic drive_write(input int v, input logic [31:0] vlr, input vec_t d,
                             input int stall_pct, input bit mid_start, input string tag,
                             output int edges, output logic [W-1:0] rda_last,
                             output logic [W-1:0] rdb_last);
    int len;
    int sent;
    int stalls;
    int pi;
    bit vld;
    len = (vlr > 32'd8) ? 8 : int'(vlr);
    sent = 0; stalls = 0; pi = 0;
    rda_last = '0; rdb_last = '0;
    wr_vreg = 3'(v); VLR = vlr; wr_start = 1'b1; wr_valid = 1'b0;
    step();
    edges = 1;
    wr_start = 1'b0; wr_vreg = 3'($urandom); VLR = $urandom;
    checks++;
    if (wr_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b expected 1", tag, wr_busy);
    end
    while (wr_done !== 1'b1 && edges < 64) begin
      if (sent < len) begin
        vld = (stall_pct < 0) ? (pi % 2 == 0) : (int'($urandom_range(99)) >= stall_pct);
        pi++;
      end else begin
        vld = 1'b0;
      end
      wr_valid = vld;
      if (vld) Write_Data = d[sent];
      else     Write_Data = $urandom;
      if (!vld && mid_start) begin
        wr_start = 1'b1; wr_vreg = 3'(v + 1); VLR = 32'd8;
      end
      step();
      edges++;
      wr_start = 1'b0;
      if (vld) begin
        sent++;
        if (sent == len) begin
          rda_last = rd_data_a;
          rdb_last = rd_data_b;
        end
      end else if (sent < len) begin
        stalls++;
      end
      checks++;
      if (wr_busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy_during_write: got %b expected 1 (edge %0d)", tag, wr_busy, edges);
      end
    end
    checks++;
    if (edges != 1 + len + stalls || sent != len) begin
      errors++;
      $display("FAIL %s done_timing: got done at edge %0d after %0d elements, expected edge %0d after %0d",
               tag, edges, sent, 1 + len + stalls, len);
    end
    // Junk valid data during DONE must not be stored.
    wr_valid = 1'b1; Write_Data = $urandom;
    step();
    wr_valid = 1'b0;
    checks++;
    if (wr_busy !== 1'b0 || wr_done !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after_done: got busy=%b done=%b expected busy=0 done=0", tag, wr_busy, wr_done);
    end
    for (int e = 0; e < len; e++) exp_mem[v][e] = d[e];
  endtask

  // Reads all 64 locations on both ports and compares with the model.
  task automatic test_storage_scan(input string tag);
    logic [W-1:0] a, b, ea, eb;
    for (int v = 0; v < NV; v++) begin
      for (int e = 0; e < VL; e++) begin
        exp_q.push_back(exp_mem[v][e]);
        exp_q.push_back(exp_mem[NV-1-v][e]);
        read_pair(v, NV-1-v, e, a, b);
        ea = exp_q.pop_front();
        eb = exp_q.pop_front();
        checks += 2;
        if (a !== ea) begin
          errors++;
          $display("FAIL %s scan_a reg%0d[%0d]: got %h expected %h", tag, v, e, a, ea);
        end
        if (b !== eb) begin
          errors++;
          $display("FAIL %s scan_b reg%0d[%0d]: got %h expected %h", tag, NV-1-v, e, b, eb);
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 pc_rst = 1'b1;
    #1;
    checks++;
    if (wr_busy !== 1'b0 || wr_done !== 1'b0 || rd_data_a !== '0 || rd_data_b !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b a=%h b=%h expected all 0",
               wr_busy, wr_done, rd_data_a, rd_data_b);
    end
    step();
    step();
    pc_rst = 1'b0;
    clear_model();
    test_storage_scan("reset");
  endtask

  task automatic test_full_write();
    vec_t d;
    int edges;
    logic [W-1:0] ra, rb, a, b;
    for (int e = 0; e < VL; e++) d[e] = 32'h10 + 32'(e);
    drive_write(2, 32'd8, d, 0, 1'b0, "full", edges, ra, rb);
    checks++;
    if (edges != 9) begin
      errors++;
      $display("FAIL full_done_latency: got %0d expected 9", edges);
    end
    for (int e = 0; e < VL; e++) begin
      read_pair(2, 0, e, a, b);
      checks++;
      if (a !== 32'h10 + 32'(e)) begin
        errors++;
        $display("FAIL full_reg2[%0d]: got %h expected %h", e, a, 32'h10 + 32'(e));
      end
    end
  endtask

  task automatic test_stall_write();
    vec_t d;
    int edges;
    logic [W-1:0] ra, rb;
    rand_vec(d);
    drive_write(5, 32'd8, d, 30, 1'b0, "preload5", edges, ra, rb);
    rand_vec(d);
    d[0] = 32'hA; d[1] = 32'hB; d[2] = 32'hC;
    drive_write(5, 32'd3, d, -1, 1'b1, "stall", edges, ra, rb);
    checks++;
    if (edges != 6) begin
      errors++;
      $display("FAIL stall_done_latency: got %0d expected 6", edges);
    end
    test_storage_scan("stall");
  endtask

  task automatic test_vlr_edges();
    vec_t d;
    int edges;
    logic [W-1:0] ra, rb;
    rand_vec(d);
    drive_write(3, 32'd8, d, 20, 1'b0, "preload3", edges, ra, rb);
    rand_vec(d);
    drive_write(3, 32'd0, d, 0, 1'b0, "vlr0", edges, ra, rb);
    checks++;
    if (edges != 1) begin
      errors++;
      $display("FAIL vlr0_done_latency: got %0d expected 1", edges);
    end
    rand_vec(d);
    drive_write(0, 32'd20, d, 0, 1'b0, "vlr20", edges, ra, rb);
    checks++;
    if (edges != 9) begin
      errors++;
      $display("FAIL vlr20_done_latency: got %0d expected 9", edges);
    end
    rand_vec(d);
    drive_write(4, 32'hFFFF_FFFF, d, 40, 1'b0, "vlrmax", edges, ra, rb);
    rand_vec(d);
    drive_write(4, 32'd1, d, 0, 1'b0, "vlr1", edges, ra, rb);
    test_storage_scan("vlr");
  endtask

  task automatic test_bypass();
    vec_t d;
    int edges;
    logic [W-1:0] ra, rb, exp_a, exp_b, old;
    rand_vec(d);
    d[4] = 32'h1234;
    drive_write(1, 32'd8, d, 0, 1'b0, "preload1", edges, ra, rb);
    rand_vec(d);
    drive_write(3, 32'd8, d, 0, 1'b0, "preload3b", edges, ra, rb);
    // Port A collides with the final write of reg1[4]; port B reads reg3[4].
    rd_vreg_a = 3'd1; rd_vreg_b = 3'd3; rd_elem = 3'd4;
    rand_vec(d);
    d[4] = 32'hDEAD;
    exp_b = exp_mem[3][4];
`ifdef VRF_WRITE_BYPASS_EN
    exp_a = 32'hDEAD;
`else
    exp_a = 32'h1234;
`endif
    drive_write(1, 32'd5, d, 0, 1'b0, "bypass_a", edges, ra, rb);
    checks += 2;
    if (ra !== exp_a) begin
      errors++;
      $display("FAIL bypass_port_a: got %h expected %h", ra, exp_a);
    end
    if (rb !== exp_b) begin
      errors++;
      $display("FAIL bypass_port_a_other_b: got %h expected %h", rb, exp_b);
    end
    // Same collision on port B only.
    rd_vreg_a = 3'd3; rd_vreg_b = 3'd1; rd_elem = 3'd2;
    old = exp_mem[1][2];
    rand_vec(d);
    d[2] = 32'hBEEF;
    exp_a = exp_mem[3][2];
`ifdef VRF_WRITE_BYPASS_EN
    exp_b = 32'hBEEF;
`else
    exp_b = old;
`endif
    drive_write(1, 32'd3, d, 0, 1'b0, "bypass_b", edges, ra, rb);
    checks += 2;
    if (rb !== exp_b) begin
      errors++;
      $display("FAIL bypass_port_b: got %h expected %h", rb, exp_b);
    end
    if (ra !== exp_a) begin
      errors++;
      $display("FAIL bypass_port_b_other_a: got %h expected %h", ra, exp_a);
    end
    test_storage_scan("bypass");
  endtask

  task automatic test_back_to_back();
    vec_t d;
    int edges;
    logic [W-1:0] ra, rb;
    rand_vec(d);
    drive_write(6, 32'd8, d, 0, 1'b0, "b2b6", edges, ra, rb);
    rand_vec(d);
    drive_write(7, 32'd8, d, 0, 1'b0, "b2b7", edges, ra, rb);
    test_storage_scan("b2b");
  endtask

  task automatic test_random();
    vec_t d;
    int edges;
    logic [W-1:0] ra, rb;
    logic [31:0] vlr;
    for (int i = 0; i < 12; i++) begin
      rand_vec(d);
      vlr = ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(10));
      drive_write(int'($urandom_range(7)), vlr, d, int'($urandom_range(60)),
                  1'($urandom_range(1)), "random", edges, ra, rb);
    end
    test_storage_scan("random");
  endtask

  task automatic test_reset_midwrite();
    wr_vreg = 3'd4; VLR = 32'd8; wr_start = 1'b1;
    step();
    wr_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; Write_Data = $urandom;
      step();
    end
    wr_valid = 1'b1; Write_Data = $urandom;
    #2 pc_rst = 1'b1;
    #1;
    checks++;
    if (wr_busy !== 1'b0 || wr_done !== 1'b0 || rd_data_a !== '0 || rd_data_b !== '0) begin
      errors++;
      $display("FAIL midwrite_reset_outputs: got busy=%b done=%b a=%h b=%h expected all 0",
               wr_busy, wr_done, rd_data_a, rd_data_b);
    end
    step();
    pc_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (wr_done !== 1'b0 || wr_busy !== 1'b0) begin
        errors++;
        $display("FAIL midwrite_no_done: got busy=%b done=%b expected 0 0 (cycle %0d)", wr_busy, wr_done, i);
      end
    end
    wr_valid = 1'b0;
    clear_model();
    test_storage_scan("midwrite_reset");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_write();
    test_stall_write();
    test_vlr_edges();
    test_bypass();
    test_back_to_back();
    test_random();
    test_reset_midwrite();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
